// File: rtl/spike_event_encoder.sv
// Spike detector and timestamped event FIFO for the Izhikevich neuron core.
// Each apply-cycle threshold crossing is stamped with the step count and queued for a valid/ready consumer.
module spike_event_encoder #(
   parameter int N     = 32,
   parameter int Q     = 16,
   parameter int TW    = 16,
   parameter int DEPTH = 8,
   parameter int DW    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               voltage,
   input  logic [N-1:0]               v_th,
   input  logic                       apply,
   output logic                       spike_out,
   output logic                       event_valid,
   input  logic                       event_ready,
   output logic [TW-1:0]              event_time,
   output logic [$clog2(DEPTH):0]     level,
   output logic [DW-1:0]              dropped,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || Q < 0 || Q >= N) begin : g_param_check
      $error("spike_event_encoder: DEPTH must be a power of 2 >= 2 and 0 <= Q < N");
   end

   logic [TW-1:0] t;
   logic [TW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          spike_q;
   logic [DW-1:0] dropped_q;
   logic          overflow_q;

   logic spike;
   logic full;
   logic empty;
   logic pop;
   logic push;
   logic drop;

   // A full FIFO still accepts a push when the head leaves on the same edge.
   always_comb begin
      spike = 1'b0;
      full  = (count == LW'(DEPTH));
      empty = (count == '0);
      pop   = 1'b0;
      push  = 1'b0;
      drop  = 1'b0;
      if (!rst) begin
         spike = apply && ($signed(voltage) > $signed(v_th));
         pop   = !empty && event_ready;
         push  = spike && (!full || pop);
         drop  = spike && full && !pop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t          <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         spike_q    <= 1'b0;
         dropped_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         spike_q <= spike;
         if (apply) begin
            t <= t + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (dropped_q != '1) begin
               dropped_q <= dropped_q + 1'b1;
            end
         end
      end
   end

   // Storage carries no reset; stale entries are hidden by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= t;
      end
   end

   assign spike_out   = spike_q;
   assign event_valid = !empty;
   assign event_time  = empty ? '0 : mem[rd_ptr];
   assign level       = count;
   assign dropped     = dropped_q;
   assign overflow    = overflow_q;

endmodule
